// File: rtl/regfile_sb_pkg.sv
// Shared sizing defaults and constants for the scoreboarded ID-stage register file.
package regfile_sb_pkg;

  localparam int unsigned REG_DATA_WIDTH = 64;
  localparam int unsigned REG_SIZE       = 32;
  localparam int unsigned REG_ADDR_WIDTH = $clog2(REG_SIZE);
  localparam int unsigned ZERO_REG       = 0;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port operand select: x0 masking, write-port bypass (highest port wins), busy masking.
module regfile_bypass_mux
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_WIDTH,
  parameter int unsigned ADDR_W = REG_ADDR_WIDTH,
  parameter int unsigned NUM_WR = 1
) (
  input  logic [ADDR_W-1:0]        rd_addr_i,
  input  logic [DATA_W-1:0]        stored_i,
  input  logic                     busy_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_busy_o
);

  logic              hit;
  logic [DATA_W-1:0] byp_data;

  // Later ports overwrite earlier matches, giving the highest index priority.
  always_comb begin
    hit      = 1'b0;
    byp_data = stored_i;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] == rd_addr_i)) begin
        hit      = 1'b1;
        byp_data = wr_data_i[w*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_data_o = byp_data;
    rd_busy_o = busy_i && !hit;
    if (rd_addr_i == ADDR_W'(ZERO_REG)) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with same-cycle write bypass and a pending-write scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int unsigned DATA_W   = REG_DATA_WIDTH,
  parameter  int unsigned NUM_REGS = REG_SIZE,
  parameter  int unsigned NUM_RD   = 2,
  parameter  int unsigned NUM_WR   = 1,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  input  logic                     flush_i,
  output logic [ADDR_W:0]          busy_cnt_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   mem_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [CNT_W-1:0]    busy_cnt_q;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Register writes: later ports applied last so port 1 wins on a collision.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))) begin
        mem_d[wr_addr_i[w*ADDR_W +: ADDR_W]] = wr_data_i[w*DATA_W +: DATA_W];
      end
    end
    mem_d[ZERO_REG] = '0;
  end

  // Scoreboard: writeback clears, a same-cycle issue re-arms, flush overrides everything.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w]) busy_d[wr_addr_i[w*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (iss_en_i) busy_d[iss_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      busy_cnt_q <= popcount(busy_d);
    end
  end

  assign busy_cnt_o = busy_cnt_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = rd_addr_i[p*ADDR_W +: ADDR_W];

    regfile_bypass_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_mux (
      .rd_addr_i (addr),
      .stored_i  (mem_q[addr]),
      .busy_i    (busy_q[addr]),
      .wr_en_i   (wr_en_i),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .rd_data_o (data),
      .rd_busy_o (busy)
    );

    // Reads are blanked while reset is held so a pending bypass cannot leak out.
    assign rd_data_o[p*DATA_W +: DATA_W] = reset ? '0 : data;
    assign rd_busy_o[p]                  = reset ? 1'b0 : busy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized checks of regfile_sb (2 read, 2 write ports) against an array-based model.
module tb_regfile_sb;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NRD*AW-1:0]  rd_addr;
  logic [NRD*DW-1:0]  rd_data;
  logic [NRD-1:0]     rd_busy;
  logic [NWR-1:0]     wr_en;
  logic [NWR*AW-1:0]  wr_addr;
  logic [NWR*DW-1:0]  wr_data;
  logic               iss_en;
  logic [AW-1:0]      iss_addr;
  logic               flush;
  logic [AW:0]        busy_cnt;

  int n_asserts = 0;
  int n_fails   = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];

  always #5 clk = ~clk;

  regfile_sb #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD),
    .NUM_WR   (NWR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .flush_i    (flush),
    .busy_cnt_o (busy_cnt)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int r = 0; r < NR; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  function automatic logic [AW-1:0] rda(input int p);
    return rd_addr[p*AW +: AW];
  endfunction

  function automatic bit wr_hits(input logic [AW-1:0] a);
    bit h = 1'b0;
    for (int w = 0; w < NWR; w++) if (wr_en[w] && wr_addr[w*AW +: AW] == a) h = 1'b1;
    return h;
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    if (a == 0) return '0;
    d = m_regs[a];
    for (int w = 0; w < NWR; w++) if (wr_en[w] && wr_addr[w*AW +: AW] == a) d = wr_data[w*DW +: DW];
    return d;
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !wr_hits(a);
  endfunction

  task automatic model_update();
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && wr_addr[w*AW +: AW] != 0) begin
        m_regs[wr_addr[w*AW +: AW]] = wr_data[w*DW +: DW];
        m_busy[wr_addr[w*AW +: AW]] = 1'b0;
      end
    end
    if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    if (flush) for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
  endtask

  // Check combinational reads, take one clock edge, then check the registered count.
  task automatic cycle();
    #1;
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("rd_data[%0d] x%0d", p, rda(p)), rd_data[p*DW +: DW], exp_data(rda(p)));
      chk($sformatf("rd_busy[%0d] x%0d", p, rda(p)), DW'(rd_busy[p]), DW'(exp_busy(rda(p))));
    end
    @(posedge clk);
    model_update();
    #1;
    chk("busy_cnt", DW'(busy_cnt), DW'(model_cnt()));
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int w, input bit en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[w] = en;
    wr_addr[w*AW +: AW] = a;
    wr_data[w*DW +: DW] = d;
  endtask

  task automatic randomize_inputs();
    for (int p = 0; p < NRD; p++) set_rd(p, AW'($urandom_range(0, 15)));
    for (int w = 0; w < NWR; w++)
      set_wr(w, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), {$urandom, $urandom});
    iss_en   = ($urandom_range(0, 2) == 0);
    iss_addr = AW'($urandom_range(0, 15));
    flush    = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    // Reset, with a write to the read address pending to exercise output blanking.
    reset = 1'b1;
    idle();
    rd_addr = {5'd3, 5'd0};
    set_wr(0, 1'b1, 5'd3, 64'hDEAD);
    model_reset();
    #2;
    chk("rst rd_data0", rd_data[0 +: DW], '0);
    chk("rst rd_data1", rd_data[DW +: DW], '0);
    chk("rst rd_busy", DW'(rd_busy), '0);
    chk("rst busy_cnt", DW'(busy_cnt), '0);
    #10;
    idle();
    reset = 1'b0;
    set_rd(0, 5'd5);
    cycle();

    // Bypass then storage read of x5.
    idle();
    set_wr(0, 1'b1, 5'd5, 64'h1234);
    set_rd(0, 5'd5);
    #1 chk("byp x5", rd_data[0 +: DW], 64'h1234);
    cycle();
    idle();
    #1 chk("stored x5", rd_data[0 +: DW], 64'h1234);
    cycle();

    // x0 stays zero.
    set_wr(0, 1'b1, 5'd0, 64'hFFFF);
    set_rd(0, 5'd0);
    #1 chk("x0 write cycle", rd_data[0 +: DW], '0);
    cycle();
    idle();
    #1 chk("x0 after", rd_data[0 +: DW], '0);
    cycle();

    // Dual-port collision on x7: port 1 wins.
    set_wr(0, 1'b1, 5'd7, 64'hAA);
    set_wr(1, 1'b1, 5'd7, 64'hBB);
    set_rd(0, 5'd7);
    #1 chk("collide byp x7", rd_data[0 +: DW], 64'hBB);
    cycle();
    idle();
    #1 chk("collide stored x7", rd_data[0 +: DW], 64'hBB);
    cycle();

    // Issue x9, then writeback while reading.
    iss_en = 1'b1; iss_addr = 5'd9;
    cycle();
    chk("cnt after iss x9", DW'(busy_cnt), 64'd1);
    idle();
    set_rd(0, 5'd9);
    #1 chk("x9 busy", DW'(rd_busy[0]), 64'd1);
    set_wr(0, 1'b1, 5'd9, 64'h99);
    #1 chk("x9 wb not busy", DW'(rd_busy[0]), 64'd0);
    cycle();
    chk("cnt after wb x9", DW'(busy_cnt), 64'd0);

    // Issue beats writeback; flush beats issue.
    idle();
    iss_en = 1'b1; iss_addr = 5'd4;
    cycle();
    set_wr(0, 1'b1, 5'd4, 64'h44);
    cycle();
    chk("cnt iss+wb x4", DW'(busy_cnt), 64'd1);
    idle();
    set_rd(0, 5'd4);
    #1 chk("x4 still busy", DW'(rd_busy[0]), 64'd1);
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
    cycle();
    chk("cnt after flush", DW'(busy_cnt), 64'd0);
    idle();
    set_rd(0, 5'd6); set_rd(1, 5'd4);
    #1 chk("flush busy", DW'(rd_busy), 64'd0);
    cycle();

    // Randomized traffic over a small address window to provoke hits.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      cycle();
    end

    // Reset asserted mid-stream, then resume.
    randomize_inputs();
    set_wr(0, 1'b1, rda(0), 64'h5555);
    reset = 1'b1;
    #1;
    model_reset();
    chk("mid rst rd_data0", rd_data[0 +: DW], '0);
    chk("mid rst rd_busy", DW'(rd_busy), '0);
    chk("mid rst busy_cnt", DW'(busy_cnt), '0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      randomize_inputs();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
